lfsr_checker: RTL and testbench

- Receive-side counterpart of the team's serial LFSR generator (`lfsr`).
- Consumes the generator's 1-bit `d_out` stream and self-synchronises to the sequence.
- After sync, free-runs a local reference, flags every bit mismatch, and counts errors and checked bits.
- Used as the on-chip BER checker at the far end of serial test links.

---
 rtl/lfsr_checker.sv | 102 ++++++++++
 tb/tb_lfsr_checker.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising serial LFSR checker with lock tracking, error pulse and saturating BER counters
module lfsr_checker #(
  parameter int width = 3,
  parameter logic [width-1:0] polynomial = 3'b110,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             d_in,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);
  typedef enum logic [1:0] {ACQUIRE, VERIFY, LOCKED} state_t;
  localparam int FW = $clog2(width + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  state_t state, state_n;
  logic [width-1:0] hist, hist_n, shl;
  logic [FW-1:0] fill, fill_n;
  logic [GW-1:0] good, good_n;
  logic [MW-1:0] miss, miss_n;
  logic [CNT_W-1:0] err_cnt_n, bit_cnt_n;
  logic err_n, pred, mis;
  assign locked = state == LOCKED;
  assign pred = ^(hist & polynomial);
  assign mis = d_in != pred;
  assign shl = hist << 1;
  always_comb begin
    state_n = state;
    hist_n = hist;
    fill_n = fill;
    good_n = good;
    miss_n = miss;
    err_n = 1'b0;
    err_cnt_n = err_cnt;
    bit_cnt_n = bit_cnt;
    if (clear) begin
      state_n = ACQUIRE;
      hist_n = '0;
      fill_n = '0;
      good_n = '0;
      miss_n = '0;
      err_cnt_n = '0;
      bit_cnt_n = '0;
    end else if (enable) begin
      case (state)
        ACQUIRE: begin
          hist_n = shl | width'(d_in);
          fill_n = fill + FW'(1);
          state_n = fill_n == FW'(width) ? VERIFY : ACQUIRE;
        end
        VERIFY: begin
          hist_n = shl | width'(d_in);
          good_n = (!mis && hist != '0) ? good + GW'(1) : '0;
          state_n = good_n == GW'(LOCK_CNT) ? LOCKED : VERIFY;
        end
        default: begin
          // the reference free-runs on its own prediction so isolated bit errors do not propagate
          hist_n = shl | width'(pred);
          bit_cnt_n = &bit_cnt ? bit_cnt : bit_cnt + CNT_W'(1);
          err_n = mis;
          err_cnt_n = (mis && !(&err_cnt)) ? err_cnt + CNT_W'(1) : err_cnt;
          miss_n = mis ? miss + MW'(1) : '0;
          if (miss_n == MW'(LOSS_CNT)) begin
            state_n = ACQUIRE;
            hist_n = '0;
            fill_n = '0;
            good_n = '0;
            miss_n = '0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state <= ACQUIRE;
      hist <= '0;
      fill <= '0;
      good <= '0;
      miss <= '0;
      error <= 1'b0;
      err_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_n;
      hist <= hist_n;
      fill <= fill_n;
      good <= good_n;
      miss <= miss_n;
      error <= err_n;
      err_cnt <= err_cnt_n;
      bit_cnt <= bit_cnt_n;
    end
  end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: randomized scoreboard bench with a sequence-level reference model of the checker
module tb_lfsr_checker;
  localparam int W = 3;
  localparam logic [W-1:0] POLY = 3'b110;
  localparam int LOCK = 4;
  localparam int LOSS = 3;
  localparam int CW = 6;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, res_n = 0, enable = 0, clear = 0, d_in = 0;
  logic locked, error;
  logic [CW-1:0] err_cnt, bit_cnt;
  lfsr_checker #(.width(W), .polynomial(POLY), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(CW)) dut (
    .clk(clk), .res_n(res_n), .enable(enable), .clear(clear), .d_in(d_in),
    .locked(locked), .error(error), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );
  always #5 clk = ~clk;
  typedef struct { bit lk; bit er; int ec; int bc; } exp_t;
  exp_t sb[$];
  int total = 0, passed = 0;
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("locked", int'(locked), int'(e.lk));
      chk("error", int'(error), int'(e.er));
      chk("err_cnt", int'(err_cnt), e.ec);
      chk("bit_cnt", int'(bit_cnt), e.bc);
    end
  end
  // reference model: the received sequence as a list of bits, with the recurrence evaluated directly
  typedef enum {M_ACQ, M_VER, M_LCK} mph_t;
  mph_t ph = M_ACQ;
  bit rx[$];
  int good = 0, miss = 0, m_ec = 0, m_bc = 0;
  bit m_er = 0;
  function automatic bit predict();
    bit o = 0;
    for (int k = 0; k < W; k++) if (POLY[k]) o ^= rx[rx.size() - 1 - k];
    return o;
  endfunction
  function automatic bit recent_zero();
    for (int k = 0; k < W; k++) if (rx[rx.size() - 1 - k]) return 0;
    return 1;
  endfunction
  task automatic model(input bit r, input bit c, input bit e, input bit d);
    bit p;
    m_er = 0;
    if (!r || c) begin
      ph = M_ACQ; rx.delete(); good = 0; miss = 0; m_ec = 0; m_bc = 0;
    end else if (e) begin
      case (ph)
        M_ACQ: begin
          rx.push_back(d);
          if (rx.size() == W) begin ph = M_VER; good = 0; end
        end
        M_VER: begin
          p = predict();
          good = (d == p && !recent_zero()) ? good + 1 : 0;
          rx.push_back(d);
          if (good == LOCK) begin ph = M_LCK; miss = 0; end
        end
        default: begin
          p = predict();
          rx.push_back(p);
          if (m_bc < MAXC) m_bc++;
          if (d != p) begin
            m_er = 1; miss++;
            if (m_ec < MAXC) m_ec++;
          end else miss = 0;
          if (miss == LOSS) begin ph = M_ACQ; rx.delete(); end
        end
      endcase
      if (rx.size() > 4 * W) void'(rx.pop_front());
    end
  endtask
  bit pat[7];
  int gi = 0;
  task automatic step(input bit r, input bit c, input bit e, input bit flip);
    exp_t x;
    @(negedge clk);
    #1;
    res_n = r; clear = c; enable = e; d_in = pat[gi] ^ flip;
    model(r, c, e, d_in);
    x.lk = ph == M_LCK; x.er = m_er; x.ec = m_ec; x.bc = m_bc;
    sb.push_back(x);
    if (e) gi = (gi + 1) % 7;
  endtask
  task automatic clean(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0);
  endtask
  initial begin
    pat = '{0, 0, 1, 0, 1, 1, 1};
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    clean(20);
    step(1, 0, 1, 1);
    clean(20);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1);
    clean(15);
    step(1, 1, 0, 0);
    for (int i = 0; i < 45; i++) step(1, 0, i % 3 == 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      res_n = 1; clear = 0; enable = 1; d_in = 0;
      model(1, 0, 1, 0);
      sb.push_back('{lk: ph == M_LCK, er: m_er, ec: m_ec, bc: m_bc});
    end
    step(1, 1, 0, 0);
    clean(10);
    for (int i = 0; i < 25; i++) step(1, 0, 1, i % 5 == 0);
    step(1, 1, 1, 0);
    clean(5);
    step(0, 0, 1, 0);
    clean(12);
    for (int i = 0; i < 300; i++) step(1, 0, 1, i % 4 == 0);
    for (int i = 0; i < 800; i++)
      step(1, $urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(9) == 0);
    repeat (3) @(negedge clk);
    chk("drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
